// File: rtl/vga_timing_generator_pkg.sv
// Shared raster constants and helpers for the VGA timing slice.
// Holds the default 640x480@60 timing, the coordinate/frame-count types and
// small helpers used by the generator. Pattern modules reuse the visible
// extents from here.
package vga_timing_generator_pkg;

  localparam int unsigned CW  = 10;  // coordinate width
  localparam int unsigned FCW = 8;   // frame counter width

  typedef logic [CW-1:0]  coord_t;
  typedef logic [FCW-1:0] fcount_t;

  // Default 640x480 at 60 Hz from a 25 MHz pixel clock
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam logic        DEF_SYNC_ACTIVE = 1'b0;  // active-low syncs

  function automatic int unsigned total4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
    return a + b + c + d;
  endfunction

  // Drive level of a sync line given its polarity and whether it is asserted
  function automatic logic sync_level(input logic active, input logic asserted);
    return asserted ? active : ~active;
  endfunction

  // Half-open window test lo <= v < hi
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle between the timing source and its consumers.
//   pixel_en    : clock enable into the generator
//   x, y        : current pixel column / line (raw counter values in blanking)
//   video_on    : inside the visible area
//   hsync/vsync : sync lines at the configured polarity
//   frame_start : strobe at pixel (0,0); line_end : strobe at last column
//   frame_count : frames completed, wraps
interface vga_timing_generator_if;
  import vga_timing_generator_pkg::*;

  logic    pixel_en;
  coord_t  x;
  coord_t  y;
  logic    video_on;
  logic    hsync;
  logic    vsync;
  logic    frame_start;
  logic    line_end;
  fcount_t frame_count;

  modport master (
    input  pixel_en,
    output x, y, video_on, hsync, vsync, frame_start, line_end, frame_count
  );

  modport slave (
    output pixel_en,
    input  x, y, video_on, hsync, vsync, frame_start, line_end, frame_count
  );

endinterface

// File: rtl/vga_timing_generator_wrap_counter.sv
// Modulo counter with enable and terminal-count flag.
//   clk, rst : clock, asynchronous active-high reset (count returns to 0)
//   en_i     : advance by one on the clock edge
//   count_o  : current count, 0..MODULUS-1
//   tc_o     : high while count_o == MODULUS-1 (independent of en_i)
module wrap_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator.
//   clock25MHz : pixel clock
//   reset      : asynchronous active-high reset
//   vga        : timing bundle (master side); pixel_en in, coordinates,
//                video_on, syncs, strobes and frame_count out
// Two wrap counters track the raster position; every output is registered
// from the same (hcnt, vcnt) so all of them describe one pixel and lag the
// counters by one enabled cycle.
module vga_timing_generator
  import vga_timing_generator_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter logic        SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic             clock25MHz,
  input  logic             reset,
  vga_timing_generator_if.master vga
);

  localparam int unsigned H_TOTAL = total4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = total4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t hcnt;
  coord_t vcnt;
  logic   h_tc;
  logic   v_tc;

  wrap_counter #(.MODULUS(H_TOTAL), .WIDTH(CW)) u_hcnt (
    .clk     (clock25MHz),
    .rst     (reset),
    .en_i    (vga.pixel_en),
    .count_o (hcnt),
    .tc_o    (h_tc)
  );

  wrap_counter #(.MODULUS(V_TOTAL), .WIDTH(CW)) u_vcnt (
    .clk     (clock25MHz),
    .rst     (reset),
    .en_i    (vga.pixel_en & h_tc),
    .count_o (vcnt),
    .tc_o    (v_tc)
  );

  coord_t  x_q, x_d;
  coord_t  y_q, y_d;
  logic    video_on_q, video_on_d;
  logic    hsync_q, hsync_d;
  logic    vsync_q, vsync_d;
  logic    frame_start_q, frame_start_d;
  logic    line_end_q, line_end_d;
  fcount_t frame_count_q, frame_count_d;
  logic    seen_wrap_q, seen_wrap_d;  // a full frame has elapsed since reset
  logic    at_origin;

  always_comb begin
    at_origin     = (hcnt == '0) && (vcnt == '0);
    x_d           = x_q;
    y_d           = y_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = frame_start_q;
    line_end_d    = line_end_q;
    frame_count_d = frame_count_q;
    seen_wrap_d   = seen_wrap_q;
    if (vga.pixel_en) begin
      x_d           = hcnt;
      y_d           = vcnt;
      video_on_d    = (hcnt < H_VIS) && (vcnt < V_VIS);
      hsync_d       = sync_level(SYNC_ACTIVE, in_window(hcnt, HS_START, HS_END));
      vsync_d       = sync_level(SYNC_ACTIVE, in_window(vcnt, VS_START, VS_END));
      frame_start_d = at_origin;
      line_end_d    = h_tc;
      // The origin presented right after reset is not a completed frame
      if (at_origin && seen_wrap_q) begin
        frame_count_d = frame_count_q + FCW'(1);
      end
      if (h_tc && v_tc) begin
        seen_wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock25MHz or posedge reset) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_count_q <= '0;
      seen_wrap_q   <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      frame_count_q <= frame_count_d;
      seen_wrap_q   <= seen_wrap_d;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_count = frame_count_q;
  // Strobe registers hold while disabled; gating with the live enable keeps
  // each strobe to exactly the enabled cycle in which its pixel is consumed.
  assign vga.frame_start = frame_start_q & vga.pixel_en;
  assign vga.line_end    = line_end_q & vga.pixel_en;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default 640x480 instance for reset, first line, hsync
// window and the enable freeze; a reduced-timing instance (16x12 raster,
// active-high syncs) for full frames, frame_count wrap, enable toggling
// and mid-frame reset.
module tb_vga_timing_generator;
  import vga_timing_generator_pkg::*;

  localparam int unsigned S_HTOT  = 16;
  localparam int unsigned S_VTOT  = 12;
  localparam int unsigned S_FRAME = 192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_timing_generator_if vif_def ();
  vga_timing_generator_if vif_sm ();

  vga_timing_generator dut_def (
    .clock25MHz (clk),
    .reset      (rst),
    .vga        (vif_def)
  );

  vga_timing_generator #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
    .SYNC_ACTIVE (1'b1)
  ) dut_sm (
    .clock25MHz (clk),
    .reset      (rst),
    .vga        (vif_sm)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model of the reduced instance
  int   cx, cy, mx, my, n_fs_model, ecnt, last_fs_e, fs_obs, vs_hi;
  logic mvalid;
  int   e_pos, e_vo, e_hs, e_vs, e_fs, e_le, e_fc, e_per, e_off;

  task automatic model_reset();
    cx = 0; cy = 0; mx = 0; my = 0; mvalid = 1'b0;
    n_fs_model = 0; ecnt = 0; last_fs_e = -1; fs_obs = 0;
  endtask

  task automatic clear_errs();
    e_pos = 0; e_vo = 0; e_hs = 0; e_vs = 0; e_fs = 0;
    e_le = 0; e_fc = 0; e_per = 0; e_off = 0;
  endtask

  task automatic flush(input string tag);
    check_eq({tag, "_pos"}, e_pos, 0);
    check_eq({tag, "_video_on"}, e_vo, 0);
    check_eq({tag, "_hsync"}, e_hs, 0);
    check_eq({tag, "_vsync"}, e_vs, 0);
    check_eq({tag, "_frame_start"}, e_fs, 0);
    check_eq({tag, "_line_end"}, e_le, 0);
    check_eq({tag, "_frame_count"}, e_fc, 0);
    check_eq({tag, "_frame_period"}, e_per, 0);
    check_eq({tag, "_strobe_while_disabled"}, e_off, 0);
    clear_errs();
  endtask

  // One clock of the reduced instance with the given enable, then compare
  task automatic sm_step(input logic en);
    logic    x_vo, x_hs, x_vs, x_fs, x_le;
    fcount_t x_fc;
    vif_sm.pixel_en = en;
    @(posedge clk);
    #1;
    if (en) begin
      mx = cx; my = cy; mvalid = 1'b1;
      cx++;
      if (cx == S_HTOT) begin
        cx = 0;
        cy++;
        if (cy == S_VTOT) cy = 0;
      end
      ecnt++;
      if (mx == 0 && my == 0) n_fs_model++;
    end
    x_vo = mvalid && mx < 8 && my < 6;
    x_hs = mvalid && mx >= 10 && mx <= 12;
    x_vs = mvalid && my >= 8 && my <= 9;
    x_fs = en && mvalid && mx == 0 && my == 0;
    x_le = en && mx == 15;
    x_fc = (n_fs_model == 0) ? 8'd0 : 8'((n_fs_model - 1) % 256);
    if (vif_sm.x !== 10'(mx) || vif_sm.y !== 10'(my)) e_pos++;
    if (vif_sm.video_on !== x_vo) e_vo++;
    if (vif_sm.hsync !== x_hs) e_hs++;
    if (vif_sm.vsync !== x_vs) e_vs++;
    if (vif_sm.frame_start !== x_fs) e_fs++;
    if (vif_sm.line_end !== x_le) e_le++;
    if (vif_sm.frame_count !== x_fc) e_fc++;
    if (!en && (vif_sm.frame_start || vif_sm.line_end)) e_off++;
    if (vif_sm.vsync === 1'b1) vs_hi++;
    if (vif_sm.frame_start === 1'b1) begin
      fs_obs++;
      if (last_fs_e >= 0 && ecnt - last_fs_e != int'(S_FRAME)) e_per++;
      last_fs_e = ecnt;
    end
  endtask

  task automatic run_to_pulse(input int target);
    int guard;
    guard = 0;
    while (fs_obs < target && guard < 300 * int'(S_FRAME)) begin
      sm_step(1'b1);
      guard++;
    end
    check_eq($sformatf("reach_pulse_%0d", target), fs_obs, target);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_le, hs_low, hs_bad, vo_bad, x_bad, frz_bad, n;
    rst = 1'b1;
    vif_def.pixel_en = 1'b1;
    vif_sm.pixel_en  = 1'b0;
    model_reset();
    clear_errs();
    repeat (5) @(posedge clk);
    #2;
    check_eq("rst_x", 32'(vif_def.x), 0);
    check_eq("rst_y", 32'(vif_def.y), 0);
    check_eq("rst_video_on", 32'(vif_def.video_on), 0);
    check_eq("rst_hsync", 32'(vif_def.hsync), 1);
    check_eq("rst_vsync", 32'(vif_def.vsync), 1);
    check_eq("rst_frame_start", 32'(vif_def.frame_start), 0);
    check_eq("rst_line_end", 32'(vif_def.line_end), 0);
    check_eq("rst_frame_count", 32'(vif_def.frame_count), 0);
    check_eq("rst_sm_hsync", 32'(vif_sm.hsync), 0);
    check_eq("rst_sm_vsync", 32'(vif_sm.vsync), 0);
    #1;
    rst = 1'b0;

    // First line of the default mode
    first_le = 0; hs_low = 0; hs_bad = 0; vo_bad = 0; x_bad = 0;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        check_eq("first_x", 32'(vif_def.x), 0);
        check_eq("first_y", 32'(vif_def.y), 0);
        check_eq("first_video_on", 32'(vif_def.video_on), 1);
        check_eq("first_frame_start", 32'(vif_def.frame_start), 1);
        check_eq("first_frame_count", 32'(vif_def.frame_count), 0);
      end
      if (vif_def.x !== 10'(k - 1) || vif_def.y !== 10'd0) x_bad++;
      if (vif_def.hsync === 1'b0) hs_low++;
      if (vif_def.hsync !== !((k - 1) >= 656 && (k - 1) <= 751)) hs_bad++;
      if (vif_def.video_on !== ((k - 1) < 640)) vo_bad++;
      if (vif_def.line_end === 1'b1 && first_le == 0) first_le = k;
    end
    check_eq("line_positions", x_bad, 0);
    check_eq("hsync_low_cycles", hs_low, 96);
    check_eq("hsync_window", hs_bad, 0);
    check_eq("video_on_line", vo_bad, 0);
    check_eq("first_line_end_cycle", first_le, 800);
    check_eq("sm_idle_x", 32'(vif_sm.x), 0);
    check_eq("sm_idle_video_on", 32'(vif_sm.video_on), 0);

    // Freeze just before the hsync pulse
    n = 0;
    while (vif_def.x !== 10'd655 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("reach_x655", 32'(vif_def.x), 655);
    vif_def.pixel_en = 1'b0;
    frz_bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (vif_def.x !== 10'd655 || vif_def.y !== 10'd1 || vif_def.hsync !== 1'b1 ||
          vif_def.frame_start !== 1'b0 || vif_def.line_end !== 1'b0) frz_bad++;
    end
    check_eq("freeze_hold", frz_bad, 0);
    vif_def.pixel_en = 1'b1;
    @(posedge clk);
    #1;
    check_eq("unfreeze_x", 32'(vif_def.x), 656);
    check_eq("unfreeze_hsync", 32'(vif_def.hsync), 0);
    vif_def.pixel_en = 1'b0;

    // Reduced instance: first frame and period
    vs_hi = 0;
    sm_step(1'b1);
    check_eq("sm_first_frame_start", 32'(vif_sm.frame_start), 1);
    check_eq("sm_first_frame_count", 32'(vif_sm.frame_count), 0);
    repeat (S_FRAME - 1) sm_step(1'b1);
    check_eq("sm_vsync_cycles", vs_hi, 32);
    sm_step(1'b1);
    check_eq("sm_second_frame_start", 32'(vif_sm.frame_start), 1);
    check_eq("sm_second_frame_count", 32'(vif_sm.frame_count), 1);
    flush("sweep");

    run_to_pulse(256);
    check_eq("frame_count_255", 32'(vif_sm.frame_count), 255);
    run_to_pulse(257);
    check_eq("frame_count_wrap", 32'(vif_sm.frame_count), 0);
    flush("frames");

    // Enable toggling: one advance per two clocks
    repeat (200) begin
      sm_step(1'b1);
      sm_step(1'b0);
    end
    flush("toggle");

    // Asynchronous reset with both syncs asserted
    n = 0;
    while (!(mx == 11 && my == 9) && n < 400) begin
      sm_step(1'b1);
      n++;
    end
    check_eq("pre_reset_hsync", 32'(vif_sm.hsync), 1);
    check_eq("pre_reset_vsync", 32'(vif_sm.vsync), 1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_rst_x", 32'(vif_sm.x), 0);
    check_eq("async_rst_y", 32'(vif_sm.y), 0);
    check_eq("async_rst_video_on", 32'(vif_sm.video_on), 0);
    check_eq("async_rst_hsync", 32'(vif_sm.hsync), 0);
    check_eq("async_rst_vsync", 32'(vif_sm.vsync), 0);
    check_eq("async_rst_frame_count", 32'(vif_sm.frame_count), 0);
    check_eq("async_rst_strobes", 32'({vif_sm.frame_start, vif_sm.line_end}), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    sm_step(1'b1);
    check_eq("restart_x", 32'(vif_sm.x), 0);
    check_eq("restart_frame_start", 32'(vif_sm.frame_start), 1);
    check_eq("restart_frame_count", 32'(vif_sm.frame_count), 0);
    repeat (S_FRAME + 20) sm_step(1'b1);
    check_eq("restart_frame_count_next", 32'(vif_sm.frame_count), 1);
    flush("restart");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
